// File: rtl/mem_bus_master_pkg.sv
// Shared types and constants for the MEM-stage bus master: FSM state encoding,
// timeout defaults and the word-alignment helper.
package mem_bus_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } busState_t;

    localparam int         TIMEOUT_CYCLES_DEFAULT = 64;
    localparam int         TIMEOUT_CNT_W          = 8;
    localparam logic [3:0] BE_FULL_WORD           = 4'b1111;

    // The bus is word-addressed; the byte offset is carried by the byte enables.
    function automatic logic [31:0] wordAlign(input logic [31:0] byteAddr);
        return byteAddr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts REQ cycles without an acknowledge; expired is high on the cycle the
// count sits at TIMEOUT_CYCLES-1.
module bus_timeout_cnt
    import mem_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMEOUT_CNT_W-1:0] LAST_COUNT = TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_CNT_W-1:0] r_count;

    // Saturates at the last count so a stuck enable can never wrap back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == LAST_COUNT);

endmodule

// File: rtl/mem_bus_master.sv
// MEM-stage bus master: turns a load/store into a single bus transaction,
// stalls the pipeline while it is outstanding and aborts it on timeout.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic        mem_flush,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        bus_err
);

    busState_t r_state;
    logic      r_stallReq;
    logic      w_access;
    logic      w_inReq;
    logic      w_expired;

    assign w_access = (mem_rd | (mem_wr & (be != 4'b0000))) & ~mem_flush;
    assign w_inReq  = (r_state == ST_REQ);

    // The IDLE term must stall in the very cycle the access appears, before any
    // register can react; reset_n keeps it quiet while reset is held.
    assign stall = r_stallReq | (reset_n & (r_state == ST_IDLE) & w_access);

    bus_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (~w_inReq),
        .enable  (w_inReq & ~bus_ack),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_stallReq  <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wdata   <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_access) begin
                        bus_addr   <= wordAlign(addr);
                        bus_wdata  <= wdata;
                        bus_be     <= mem_wr ? be : BE_FULL_WORD;
                        bus_we     <= mem_wr;
                        bus_req    <= 1'b1;
                        r_stallReq <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // An acknowledge in the timeout cycle still completes normally.
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        r_stallReq <= 1'b0;
                        if (!bus_we) begin
                            rdata       <= bus_rdata;
                            rdata_valid <= 1'b1;
                        end
                        r_state <= ST_DONE;
                    end else if (w_expired) begin
                        bus_req    <= 1'b0;
                        r_stallReq <= 1'b0;
                        bus_err    <= 1'b1;
                        rdata      <= '0;
                        r_state    <= ST_ERR;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                ST_ERR:  r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: per-scenario tasks with a queue of
// expected bus transactions popped when the DUT completes each one.
module tb_mem_bus_master;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_rd, mem_wr, mem_flush;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        bus_err;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        isErr;
    } expTxn_t;

    expTxn_t expQ[$];

    mem_bus_master #(
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_flush   (mem_flush),
        .addr        (addr),
        .wdata       (wdata),
        .be          (be),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic expTxn_t makeTxn(input logic [31:0] a, input logic [3:0] b, input logic w,
                                        input logic [31:0] wd, input logic [31:0] rd, input logic e);
        expTxn_t t;
        t.addr  = a;
        t.be    = b;
        t.we    = w;
        t.wdata = wd;
        t.rdata = rd;
        t.isErr = e;
        return t;
    endfunction

    // Inputs change just after the rising edge; outputs are sampled on the falling edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mem_rd = 1'b1; mem_wr = 1'b0; mem_flush = 1'b0;
        addr = 32'h0000_1000; wdata = 32'h0; be = 4'h0; bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_bus_req got=%b exp=0", bus_req); end
        vectors++; if (bus_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_bus_we got=%b exp=0", bus_we); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stall got=%b exp=0", stall); end
        vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_rdata_valid got=%b exp=0", rdata_valid); end
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_bus_err got=%b exp=0", bus_err); end
        vectors++; if (bus_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_bus_addr got=%h exp=0", bus_addr); end
        vectors++; if (bus_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_bus_wdata got=%h exp=0", bus_wdata); end
        vectors++; if (bus_be !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_bus_be got=%h exp=0", bus_be); end
        vectors++; if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_rdata got=%h exp=0", rdata); end
        nextCycle();
        mem_rd  = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_idle_stall got=%b exp=0", stall); end
        nextCycle();
    endtask

    task automatic test_load_zero_wait();
        int stallCycles = 0;
        mem_rd = 1'b1; addr = 32'h0000_1006;
        expQ.push_back(makeTxn(32'h0000_1004, 4'hF, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0));
        @(negedge clk); if (stall) stallCycles++;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL ld_idle_stall got=%b exp=1", stall); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL ld_idle_req got=%b exp=0", bus_req); end
        nextCycle();
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk); if (stall) stallCycles++;
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL ld_req got=%b exp=1", bus_req); end
        vectors++; if (bus_addr !== expQ[0].addr) begin miscompares++; $display("[TB] FAIL ld_bus_addr got=%h exp=%h", bus_addr, expQ[0].addr); end
        vectors++; if (bus_be !== expQ[0].be) begin miscompares++; $display("[TB] FAIL ld_bus_be got=%b exp=%b", bus_be, expQ[0].be); end
        vectors++; if (bus_we !== expQ[0].we) begin miscompares++; $display("[TB] FAIL ld_bus_we got=%b exp=%b", bus_we, expQ[0].we); end
        nextCycle();
        bus_ack = 1'b0; bus_rdata = 32'h0BAD_BEEF;
        @(negedge clk); if (stall) stallCycles++;
        vectors++; if (rdata_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL ld_valid got=%b exp=1", rdata_valid); end
        vectors++; if (rdata !== expQ[0].rdata) begin miscompares++; $display("[TB] FAIL ld_rdata got=%h exp=%h", rdata, expQ[0].rdata); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL ld_done_req got=%b exp=0", bus_req); end
        void'(expQ.pop_front());
        nextCycle();
        mem_rd = 1'b0;
        @(negedge clk); if (stall) stallCycles++;
        vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL ld_valid_pulse got=%b exp=0", rdata_valid); end
        vectors++; if (stallCycles != 2) begin miscompares++; $display("[TB] FAIL ld_stall_cycles got=%0d exp=2", stallCycles); end
        nextCycle();
    endtask

    task automatic test_store_wait();
        int stallCycles = 0;
        mem_wr = 1'b1; be = 4'b1100; wdata = 32'hBEEF_0000; addr = 32'h0000_2002;
        expQ.push_back(makeTxn(32'h0000_2000, 4'b1100, 1'b1, 32'hBEEF_0000, 32'h0, 1'b0));
        @(negedge clk); if (stall) stallCycles++;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL st_idle_stall got=%b exp=1", stall); end
        for (int c = 1; c <= 4; c++) begin
            nextCycle();
            bus_ack = (c == 4);
            if (c == 2) mem_flush = 1'b1;
            if (c == 3) begin addr = 32'hFFFF_FFF0; wdata = 32'h1234_5678; be = 4'b0011; end
            @(negedge clk); if (stall) stallCycles++;
            vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL st_req_c%0d got=%b exp=1", c, bus_req); end
            vectors++; if (bus_addr !== expQ[0].addr) begin miscompares++; $display("[TB] FAIL st_addr_c%0d got=%h exp=%h", c, bus_addr, expQ[0].addr); end
            vectors++; if (bus_be !== expQ[0].be) begin miscompares++; $display("[TB] FAIL st_be_c%0d got=%b exp=%b", c, bus_be, expQ[0].be); end
            vectors++; if (bus_we !== expQ[0].we) begin miscompares++; $display("[TB] FAIL st_we_c%0d got=%b exp=%b", c, bus_we, expQ[0].we); end
            vectors++; if (bus_wdata !== expQ[0].wdata) begin miscompares++; $display("[TB] FAIL st_wdata_c%0d got=%h exp=%h", c, bus_wdata, expQ[0].wdata); end
        end
        nextCycle();
        bus_ack = 1'b0; mem_flush = 1'b0;
        @(negedge clk); if (stall) stallCycles++;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL st_done_req got=%b exp=0", bus_req); end
        vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL st_no_valid got=%b exp=0", rdata_valid); end
        vectors++; if (bus_err !== expQ[0].isErr) begin miscompares++; $display("[TB] FAIL st_ack_wins got=%b exp=%b", bus_err, expQ[0].isErr); end
        void'(expQ.pop_front());
        nextCycle();
        mem_wr = 1'b0; be = 4'h0;
        @(negedge clk); if (stall) stallCycles++;
        vectors++; if (stallCycles != 5) begin miscompares++; $display("[TB] FAIL st_stall_cycles got=%0d exp=5", stallCycles); end
        nextCycle();
    endtask

    task automatic test_rd_wr_both();
        mem_rd = 1'b1; mem_wr = 1'b1; be = 4'b0011; wdata = 32'h0000_1234; addr = 32'h0000_0040;
        expQ.push_back(makeTxn(32'h0000_0040, 4'b0011, 1'b1, 32'h0000_1234, 32'h0, 1'b0));
        @(negedge clk);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rw_idle_stall got=%b exp=1", stall); end
        nextCycle();
        bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
        @(negedge clk);
        vectors++; if (bus_we !== expQ[0].we) begin miscompares++; $display("[TB] FAIL rw_we got=%b exp=%b", bus_we, expQ[0].we); end
        vectors++; if (bus_be !== expQ[0].be) begin miscompares++; $display("[TB] FAIL rw_be got=%b exp=%b", bus_be, expQ[0].be); end
        vectors++; if (bus_wdata !== expQ[0].wdata) begin miscompares++; $display("[TB] FAIL rw_wdata got=%h exp=%h", bus_wdata, expQ[0].wdata); end
        nextCycle();
        bus_ack = 1'b0;
        @(negedge clk);
        vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_no_valid got=%b exp=0", rdata_valid); end
        void'(expQ.pop_front());
        nextCycle();
        mem_rd = 1'b0; mem_wr = 1'b0; be = 4'h0;
        @(negedge clk);
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rw_end_stall got=%b exp=0", stall); end
        nextCycle();
    endtask

    task automatic test_timeout();
        mem_rd = 1'b1; addr = 32'h0000_3000; bus_ack = 1'b0;
        expQ.push_back(makeTxn(32'h0000_3000, 4'hF, 1'b0, 32'h0, 32'h0, 1'b1));
        @(negedge clk);
        for (int c = 1; c <= TB_TIMEOUT; c++) begin
            nextCycle();
            @(negedge clk);
            vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL to_req_c%0d got=%b exp=1", c, bus_req); end
            vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_early_err_c%0d got=%b exp=0", c, bus_err); end
        end
        nextCycle();
        @(negedge clk);
        vectors++; if (bus_err !== expQ[0].isErr) begin miscompares++; $display("[TB] FAIL to_err got=%b exp=%b", bus_err, expQ[0].isErr); end
        vectors++; if (rdata !== expQ[0].rdata) begin miscompares++; $display("[TB] FAIL to_rdata got=%h exp=%h", rdata, expQ[0].rdata); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL to_stall got=%b exp=0", stall); end
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL to_req_drop got=%b exp=0", bus_req); end
        vectors++; if (rdata_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL to_valid got=%b exp=0", rdata_valid); end
        void'(expQ.pop_front());
        nextCycle();
        mem_rd = 1'b0;
        @(negedge clk);
        vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL to_err_pulse got=%b exp=0", bus_err); end
        nextCycle();
    endtask

    task automatic test_filter();
        mem_wr = 1'b1; be = 4'b0000; addr = 32'h0000_4000;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL flt_be0_stall_c%0d got=%b exp=0", c, stall); end
            vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL flt_be0_req_c%0d got=%b exp=0", c, bus_req); end
            nextCycle();
        end
        mem_wr = 1'b0; mem_rd = 1'b1; mem_flush = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL flt_flush_stall_c%0d got=%b exp=0", c, stall); end
            vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL flt_flush_req_c%0d got=%b exp=0", c, bus_req); end
            nextCycle();
        end
        mem_rd = 1'b0; mem_flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        mem_rd = 1'b1; addr = 32'h0000_5004; bus_ack = 1'b0;
        @(negedge clk);
        nextCycle();
        @(negedge clk);
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_req1 got=%b exp=1", bus_req); end
        nextCycle();
        vectors++; if (bus_req !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_req2 got=%b exp=1", bus_req); end
        #2 reset_n = 1'b0;
        #1;
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_async_req got=%b exp=0", bus_req); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_async_stall got=%b exp=0", stall); end
        expQ.delete();
        nextCycle();
        mem_rd = 1'b0; reset_n = 1'b1;
        @(negedge clk);
        vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL rm_rel_req got=%b exp=0", bus_req); end
        nextCycle();
        mem_rd = 1'b1; addr = 32'h0000_6008;
        expQ.push_back(makeTxn(32'h0000_6008, 4'hF, 1'b0, 32'h0, 32'h600D_CAFE, 1'b0));
        @(negedge clk);
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL rm_idle_stall got=%b exp=1", stall); end
        nextCycle();
        bus_ack = 1'b1; bus_rdata = 32'h600D_CAFE;
        @(negedge clk);
        vectors++; if (bus_addr !== expQ[0].addr) begin miscompares++; $display("[TB] FAIL rm_addr got=%h exp=%h", bus_addr, expQ[0].addr); end
        nextCycle();
        bus_ack = 1'b0;
        @(negedge clk);
        vectors++; if (rdata !== expQ[0].rdata) begin miscompares++; $display("[TB] FAIL rm_rdata got=%h exp=%h", rdata, expQ[0].rdata); end
        void'(expQ.pop_front());
        nextCycle();
        mem_rd = 1'b0;
        @(negedge clk);
        nextCycle();
    endtask

    task automatic test_back_to_back();
        int validSeen = 0;
        bus_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_rd    = 1'b1;
            addr      = 32'h0000_7000 + 32'(k * 4) + 32'(k % 4);
            bus_rdata = 32'hA5A5_0000 + 32'(k);
            expQ.push_back(makeTxn(32'h0000_7000 + 32'(k * 4), 4'hF, 1'b0, 32'h0, 32'hA5A5_0000 + 32'(k), 1'b0));
            @(negedge clk);
            vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_idle_stall_%0d got=%b exp=1", k, stall); end
            vectors++; if (bus_req !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle_req_%0d got=%b exp=0", k, bus_req); end
            nextCycle();
            @(negedge clk);
            vectors++; if (stall !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_req_stall_%0d got=%b exp=1", k, stall); end
            vectors++; if (bus_addr !== expQ[0].addr) begin miscompares++; $display("[TB] FAIL b2b_addr_%0d got=%h exp=%h", k, bus_addr, expQ[0].addr); end
            nextCycle();
            @(negedge clk);
            if (rdata_valid === 1'b1) validSeen++;
            vectors++; if (stall !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_done_stall_%0d got=%b exp=0", k, stall); end
            vectors++; if (rdata !== expQ[0].rdata) begin miscompares++; $display("[TB] FAIL b2b_rdata_%0d got=%h exp=%h", k, rdata, expQ[0].rdata); end
            void'(expQ.pop_front());
            nextCycle();
        end
        mem_rd = 1'b0; bus_ack = 1'b0;
        vectors++; if (validSeen != 4) begin miscompares++; $display("[TB] FAIL b2b_valid_count got=%0d exp=4", validSeen); end
        vectors++; if (expQ.size() != 0) begin miscompares++; $display("[TB] FAIL b2b_queue_left got=%0d exp=0", expQ.size()); end
        @(negedge clk);
        nextCycle();
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_wait();
        test_rd_wr_both();
        test_timeout();
        test_filter();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64; the number of REQ cycles without bus_ack that aborts the transaction; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 mem_rd  input  1  the MEM-stage instruction is a load.
REQ-005 mem_wr  input  1  the MEM-stage instruction is a store.
REQ-006 mem_flush  input  1  the MEM-stage instruction is cancelled and must not start a transaction.
REQ-007 addr  input  32  byte address from the EX/MEM register.
REQ-008 wdata  input  32  store data, already lane-aligned.
REQ-009 be  input  4  store byte enables from the byte-enable generator.
REQ-010 bus_ack  input  1  slave completes the current transaction this cycle.
REQ-011 bus_rdata  input  32  slave read data; valid only when bus_ack=1.
REQ-012 bus_req  output  1  transaction request.
REQ-013 bus_we  output  1  1 = write, 0 = read.
REQ-014 bus_addr  output  32  word address, with bits [1:0] forced to 0.
REQ-015 bus_be  output  4  bus byte enables.
REQ-016 bus_wdata  output  32  bus write data.
REQ-017 stall  output  1  freezes the pipeline at and before MEM.
REQ-018 rdata  output  32  captured load word.
REQ-019 rdata_valid  output  1  one-cycle pulse: rdata holds a new load word.
REQ-020 bus_err  output  1  one-cycle pulse: the transaction timed out.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, REQ, DONE and ERR.
REQ-022 An access SHALL be (mem_rd | (mem_wr & be != 0)) & ~mem_flush, sampled only in IDLE.
REQ-023 A store with be = 0 SHALL start no transaction and SHALL NOT assert stall.
REQ-024 If mem_rd and mem_wr are both 1, the block SHALL perform a write.
REQ-025 In IDLE with an access, the block SHALL:
- latch addr, wdata, be (or 4'b1111 for a read) and we;
- assert stall combinationally in that same cycle;
- move to REQ.
REQ-026 In REQ, the outputs SHALL be:
- bus_req = 1;
- stall = 1;
- bus_addr, bus_we, bus_be and bus_wdata driven from the latched values, held stable until the state is exited.
REQ-027 In REQ with bus_ack = 1, the block SHALL move to DONE and, for a read, capture bus_rdata into rdata.
REQ-028 A timeout counter SHALL behave as follows:
- clear on entry to REQ;
- increment once per REQ cycle without bus_ack;
- on the cycle the count reaches TIMEOUT_CYCLES-1 without bus_ack, the block moves to ERR.
REQ-029 bus_ack arriving in the same cycle as the timeout SHALL win; the block moves to DONE.
REQ-030 In DONE, the outputs SHALL be stall = 0 and bus_req = 0, and rdata_valid = 1 for a read only; the block then returns to IDLE unconditionally.
REQ-031 In ERR, the outputs SHALL be stall = 0, bus_req = 0, bus_err = 1 and rdata = 0; the block then returns to IDLE.
REQ-032 DONE and ERR SHALL ignore mem_rd, mem_wr and mem_flush; the next access is sampled in the following IDLE cycle.
REQ-033 mem_flush asserted while in REQ SHALL NOT abort the transaction.
REQ-034 Every access SHALL have stall high for at least 2 cycles; a zero-wait slave (ack on the first REQ cycle) gives exactly 2 stall cycles.
REQ-035 bus_ack seen outside REQ SHALL be ignored.

Reset
REQ-036 While reset_n = 0, the following SHALL hold:
- the state is IDLE and the timeout counter is 0;
- rdata, bus_addr, bus_wdata and bus_be are 0;
- bus_req, bus_we, stall, rdata_valid and bus_err are 0.
REQ-037 Reset asserted mid-transaction SHALL drop bus_req immediately, without waiting for the clock edge.

Structure
REQ-038 The FSM state encodings and the TIMEOUT_CYCLES default SHALL live in the shared CPU package/header.
REQ-039 The timeout counter SHALL be a sub-module, bus_timeout_cnt (clear, enable, expired).

Verification
REQ-040 Load, zero-wait: mem_rd=1, addr=0x1006, ack on the first REQ cycle with bus_rdata=0xCAFEF00D -> the bench SHALL see:
- bus_addr = 0x1004, bus_be = 1111, we = 0;
- stall high for 2 cycles;
- rdata = 0xCAFEF00D with rdata_valid for 1 cycle.
REQ-041 Store halfword: mem_wr=1, be=1100, wdata=0xBEEF0000, ack after 3 REQ cycles -> the bench SHALL see:
- bus_be = 1100 and bus_we = 1;
- bus outputs stable for 4 REQ cycles;
- stall high for 5 cycles;
- no rdata_valid.
REQ-042 Timeout: TIMEOUT_CYCLES=4, mem_rd=1, no ack -> bus_err SHALL pulse in the cycle after the 4th REQ cycle, with rdata = 0 and stall = 0 in that cycle.
REQ-043 Filtering: mem_wr=1 with be=0000, and separately mem_rd=1 with mem_flush=1 -> bus_req and stall SHALL stay 0.
REQ-044 Reset pulsed low on the 2nd REQ cycle -> bus_req and stall SHALL fall asynchronously, and after release the block SHALL be in IDLE.
REQ-045 Back-to-back loads with a zero-wait slave -> the pattern SHALL repeat every 3 cycles (stall 2 cycles, DONE 1 cycle), with no dropped access.
